// File: rtl/hidden_wires_arbiter.sv
// Packet-level round-robin arbiter sharing one hidden_wires_t channel.
// Grant is held from the first beat to EOP; output is a registered stream.
module hidden_wires_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0][33:0]   req_wires,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic [33:0]                out_wires,
   input  logic                       out_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic [CNT_W-1:0]           pkt_count,
   output logic                       frame_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } hidden_wires_t;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t               state, state_nx;
   logic [IW-1:0]        rr_ptr, pick, off;
   logic [IW:0]          sum;
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic                 found, first, can_load, acc;
   hidden_wires_t        beat;

   // rotate so bit 0 is rr_ptr, take lowest set bit, rotate back
   always_comb begin
      dbl   = {req_valid, req_valid} >> rr_ptr;
      rot   = dbl[NUM_REQ-1:0];
      found = 1'b0;
      off   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = IW'(i);
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= NR) sum = sum - NR;
      pick = sum[IW-1:0];
   end

   assign beat     = hidden_wires_t'(req_wires[grant_id]);
   assign can_load = !out_valid || out_ready;
   assign acc      = (state == LOCK) && req_valid[grant_id] && can_load;
   assign busy     = (state == LOCK);

   always_comb begin
      req_ready = '0;
      if (state == LOCK) req_ready[grant_id] = can_load;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (found) state_nx = LOCK;
         LOCK:    if (acc && beat.eop) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_wires <= '0;
         grant_id  <= '0;
         rr_ptr    <= '0;
         pkt_count <= '0;
         frame_err <= 1'b0;
         first     <= 1'b0;
      end else begin
         if (state == IDLE && found) begin
            grant_id <= pick;
            first    <= 1'b1;
         end
         if (acc) begin
            out_valid <= 1'b1;
            out_wires <= beat;
            first     <= 1'b0;
            // SOP must appear exactly on the first beat of the lock
            if (first != beat.sop) frame_err <= 1'b1;
            if (beat.eop) begin
               pkt_count <= pkt_count + CNT_W'(1);
               rr_ptr    <= (grant_id == IW'(NUM_REQ-1)) ? '0
                                                         : grant_id + IW'(1);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hidden_wires_arbiter.sv
// Bench for hidden_wires_arbiter: directed packets plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_hidden_wires_arbiter;

   localparam int N  = 4;
   localparam int CW = 4;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [N-1:0]         req_valid;
   logic [N-1:0][33:0]   req_wires;
   logic [N-1:0]         req_ready;
   logic                 out_valid;
   logic [33:0]          out_wires;
   logic                 out_ready;
   logic [1:0]           grant_id;
   logic                 busy;
   logic [CW-1:0]        pkt_count;
   logic                 frame_err;

   always #5 clk = ~clk;

   hidden_wires_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_wires(req_wires), .req_ready(req_ready),
      .out_valid(out_valid), .out_wires(out_wires), .out_ready(out_ready),
      .grant_id(grant_id), .busy(busy),
      .pkt_count(pkt_count), .frame_err(frame_err)
   );

   int checks = 0;
   int errors = 0;

   logic [33:0] src [N][$];
   logic [33:0] deliv[$];
   logic [33:0] expq[$];

   int          m_owner, m_rr, m_gid, m_cnt;
   bit          m_ov, m_ferr, m_first;
   logic [33:0] m_ow;

   int           ready_mode = 0;
   int           cycn = 0;
   bit           rnd_valid = 0;
   logic [N-1:0] prev_v, prev_acc;
   int           npk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] mk(bit s, bit e, logic [31:0] d);
      return {s, e, d};
   endfunction

   task automatic push_pkt(input int r, input int n, input logic [31:0] base,
                           input bit to_src, input bit to_exp);
      for (int i = 0; i < n; i++) begin
         logic [33:0] w;
         w = mk(i == 0, i == n-1, base + 32'(i));
         if (to_src) src[r].push_back(w);
         if (to_exp) expq.push_back(w);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_gid = 0; m_cnt = 0;
      m_ov = 0; m_ferr = 0; m_first = 0; m_ow = '0;
   endtask

   // one clock of the arbiter, described in packet/handshake terms
   task automatic model_step(input logic [N-1:0] v,
                             input logic [N-1:0][33:0] w,
                             input logic ordy);
      if (m_owner < 0) begin
         if (ordy) m_ov = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (v[c]) begin
               m_owner = c; m_gid = c; m_first = 1;
               break;
            end
         end
      end else begin
         if (v[m_owner] && (!m_ov || ordy)) begin
            logic [33:0] b;
            b = w[m_owner];
            if ((m_first && !b[33]) || (!m_first && b[33])) m_ferr = 1;
            m_first = 0;
            m_ov = 1;
            m_ow = b;
            if (b[32]) begin
               m_cnt = (m_cnt + 1) % (1 << CW);
               m_rr = (m_owner + 1) % N;
               m_owner = -1;
            end
         end else if (ordy) begin
            m_ov = 0;
         end
      end
   endtask

   task automatic cyc();
      logic [N-1:0]       rs, ev, v_s;
      logic [N-1:0][33:0] w_s;
      logic               ordy_s;
      cycn++;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cycn % 4 == 0) || (cycn % 4 == 3);
         default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
      for (int r = 0; r < N; r++) begin
         bit g;
         g = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (prev_v[r] && !prev_acc[r]) g = 1'b1;
         req_valid[r] = g && (src[r].size() > 0);
         req_wires[r] = (src[r].size() > 0) ? src[r][0] : '0;
      end
      #1;
      ev = '0;
      if (m_owner >= 0) ev[m_owner] = !m_ov || out_ready;
      chk("req_ready", 64'(req_ready), 64'(ev));
      rs = req_ready; v_s = req_valid; w_s = req_wires; ordy_s = out_ready;
      if (out_valid && out_ready) deliv.push_back(out_wires);
      @(posedge clk);
      model_step(v_s, w_s, ordy_s);
      for (int r = 0; r < N; r++)
         if (v_s[r] && rs[r]) void'(src[r].pop_front());
      prev_v = v_s;
      prev_acc = v_s & rs;
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_wires", 64'(out_wires), 64'(m_ow));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
      chk("frame_err", 64'(frame_err), 64'(m_ferr));
   endtask

   function automatic bit all_idle();
      bit idle;
      idle = (m_owner < 0) && !m_ov;
      for (int r = 0; r < N; r++) if (src[r].size() != 0) idle = 0;
      return idle;
   endfunction

   task automatic run_done(input string tag, input int budget);
      for (int i = 0; i < budget && !all_idle(); i++) cyc();
      chk({tag, "_done"}, 64'(all_idle()), 64'(1));
   endtask

   task automatic cmp_deliv(input string tag);
      chk({tag, "_len"}, 64'(deliv.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < deliv.size(); i++)
         chk({tag, "_beat"}, 64'(deliv[i]), 64'(expq[i]));
      deliv.delete();
      expq.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_out_wires"}, 64'(out_wires), 64'(0));
      chk({tag, "_grant_id"},  64'(grant_id),  64'(0));
      chk({tag, "_busy"},      64'(busy),      64'(0));
      chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(0));
      chk({tag, "_frame_err"}, 64'(frame_err), 64'(0));
   endtask

   initial begin
      req_valid = '0; req_wires = '0; out_ready = 1'b0;
      prev_v = '0; prev_acc = '0;
      model_reset();
      #3;
      chk_reset_vals("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;

      // 3-beat packet from requester 0
      push_pkt(0, 3, 32'hA0, 1, 1);
      cyc();
      chk("t1_grant_busy", 64'(busy), 64'(1));
      chk("t1_grant_id", 64'(grant_id), 64'(0));
      run_done("t1", 50);
      cmp_deliv("t1");
      chk("t1_count", 64'(pkt_count), 64'(1));
      chk("t1_busy_low", 64'(busy), 64'(0));

      // single beat from 3 brings the pointer back to 0
      push_pkt(3, 1, 32'h3F, 1, 1);
      run_done("prep", 20);
      cmp_deliv("prep");

      // three contenders, requester 0 re-requests after 2
      push_pkt(0, 2, 32'h100, 1, 0);
      push_pkt(0, 2, 32'h400, 1, 0);
      push_pkt(1, 2, 32'h200, 1, 0);
      push_pkt(2, 2, 32'h300, 1, 0);
      push_pkt(0, 2, 32'h100, 0, 1);
      push_pkt(1, 2, 32'h200, 0, 1);
      push_pkt(2, 2, 32'h300, 0, 1);
      push_pkt(0, 2, 32'h400, 0, 1);
      run_done("t2", 100);
      cmp_deliv("t2");
      chk("t2_count", 64'(pkt_count), 64'(6));

      // backpressure with out_ready pattern 1,0,0,1
      ready_mode = 1;
      cycn = 0;
      push_pkt(1, 4, 32'hB0, 1, 1);
      run_done("t3", 100);
      cmp_deliv("t3");
      ready_mode = 0;
      chk("t3_count", 64'(pkt_count), 64'(7));

      // single-beat packets from 3 and 1; pointer is at 2
      push_pkt(3, 1, 32'hC3, 1, 0);
      push_pkt(1, 1, 32'hC1, 1, 0);
      push_pkt(3, 1, 32'hC3, 0, 1);
      push_pkt(1, 1, 32'hC1, 0, 1);
      run_done("t4", 50);
      cmp_deliv("t4");
      chk("t4_count", 64'(pkt_count), 64'(9));

      // framing violation: SOP on the second beat instead of the first
      src[2].push_back(mk(0, 0, 32'hF0));
      src[2].push_back(mk(1, 0, 32'hF1));
      src[2].push_back(mk(0, 1, 32'hF2));
      expq.push_back(mk(0, 0, 32'hF0));
      expq.push_back(mk(1, 0, 32'hF1));
      expq.push_back(mk(0, 1, 32'hF2));
      run_done("t5", 50);
      cmp_deliv("t5");
      chk("t5_frame_err", 64'(frame_err), 64'(1));
      chk("t5_count", 64'(pkt_count), 64'(10));

      // randomized traffic, counter wraps several times
      rnd_valid = 1;
      ready_mode = 2;
      npk = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            push_pkt(int'($urandom_range(0, N-1)),
                     int'($urandom_range(1, 4)), $urandom, 1, 0);
            npk++;
         end
         cyc();
      end
      run_done("rand", 3000);
      deliv.delete();
      chk("rand_count", 64'(pkt_count), 64'((10 + npk) % (1 << CW)));
      chk("rand_sticky", 64'(frame_err), 64'(1));
      rnd_valid = 0;
      ready_mode = 0;

      // reset in the middle of a 5-beat packet
      push_pkt(0, 5, 32'hD0, 1, 0);
      for (int i = 0; i < 20 && deliv.size() < 2; i++) cyc();
      chk("mid_two_beats", 64'(deliv.size()), 64'(2));
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      model_reset();
      for (int r = 0; r < N; r++) src[r].delete();
      deliv.delete();
      expq.delete();
      req_valid = '0;
      prev_v = '0;
      prev_acc = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      push_pkt(2, 3, 32'hE0, 1, 1);
      run_done("post", 50);
      cmp_deliv("post");
      chk("post_count", 64'(pkt_count), 64'(1));
      chk("post_frame_err", 64'(frame_err), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
